// File: rtl/exec_seq_ctrl.sv
// Multi-cycle sequencer: fetch, execute, optional load/store, commit.
// Halts on ebreak or when any wait state exceeds the watchdog limit.
module exec_seq_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    output logic [DATA_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_valid,
    input  logic [31:0]           ifu_rsp_data,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic                  is_mem,
    input  logic                  is_ebreak,
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    input  logic                  lsu_rsp_valid,
    output logic                  pc_we,
    output logic                  rf_we_en,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE, FETCH, IWAIT, EXEC, MEM, MWAIT, COMMIT, HALT
    } state_t;

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic              wd_tick, progress, timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wd          <= '0;
            inst        <= NOP;
            timeout_err <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            if (state == IWAIT && ifu_rsp_valid)
                inst <= ifu_rsp_data;
            if (timeout_hit)
                timeout_err <= 1'b1;
            if (state == COMMIT)
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        wd_tick     = 1'b0;
        progress    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                wd_tick  = 1'b1;
                progress = ifu_req_ready;
                if (ifu_req_ready) state_nxt = IWAIT;
            end
            IWAIT: begin
                wd_tick  = 1'b1;
                progress = ifu_rsp_valid;
                if (ifu_rsp_valid) state_nxt = EXEC;
            end
            EXEC: begin
                if (is_ebreak)   state_nxt = HALT;
                else if (is_mem) state_nxt = MEM;
                else             state_nxt = COMMIT;
            end
            MEM: begin
                wd_tick  = 1'b1;
                progress = lsu_req_ready;
                if (lsu_req_ready) state_nxt = MWAIT;
            end
            MWAIT: begin
                wd_tick  = 1'b1;
                progress = lsu_rsp_valid;
                if (lsu_rsp_valid) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
        // A handshake or response on the final allowed cycle still wins.
        if (wd_tick && !progress && wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_nxt   = HALT;
        end
        wd_nxt = (state_nxt != state || !wd_tick) ? '0 : wd + WD_W'(1);
    end

    assign ifu_req_valid = (state == FETCH);
    assign ifu_req_addr  = pc;
    assign inst_valid    = (state == EXEC);
    assign lsu_req_valid = (state == MEM);
    assign pc_we         = (state == COMMIT);
    assign rf_we_en      = (state == COMMIT);
    assign halted        = (state == HALT);

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl; a second 4-bit-counter instance checks wrap.
module tb_exec_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'h8000_0000;
    logic        ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_data = 32'h0;
    logic        is_mem = 1'b0, is_ebreak = 1'b0;
    logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;

    logic        ifu_req_valid, inst_valid, lsu_req_valid, pc_we, rf_we_en, halted, timeout_err;
    logic [31:0] ifu_req_addr, inst, retire_cnt;
    logic        ifu_req_valid4, inst_valid4, lsu_req_valid4, pc_we4, rf_we_en4, halted4, timeout_err4;
    logic [31:0] ifu_req_addr4, inst4;
    logic [3:0]  retire_cnt4;

    int tests = 0, failed = 0, exp_cnt = 0;

    always #5 clk = ~clk;

    exec_seq_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .inst(inst), .inst_valid(inst_valid), .is_mem(is_mem), .is_ebreak(is_ebreak),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .pc_we(pc_we), .rf_we_en(rf_we_en), .halted(halted), .timeout_err(timeout_err),
        .retire_cnt(retire_cnt)
    );

    exec_seq_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .pc(pc),
        .ifu_req_valid(ifu_req_valid4), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr4),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .inst(inst4), .inst_valid(inst_valid4), .is_mem(is_mem), .is_ebreak(is_ebreak),
        .lsu_req_valid(lsu_req_valid4), .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .pc_we(pc_we4), .rf_we_en(rf_we_en4), .halted(halted4), .timeout_err(timeout_err4),
        .retire_cnt(retire_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ifu_valid"}, ifu_req_valid, 0);
        chk({tag, "_lsu_valid"}, lsu_req_valid, 0);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_pc_we"}, pc_we, 0);
        chk({tag, "_rf_we"}, rf_we_en, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_inst"}, inst, 64'h13);
        chk({tag, "_retire"}, retire_cnt, 0);
    endtask

    // From a FETCH-cycle negedge to the EXEC-cycle negedge, zero-wait memory.
    task automatic fetch_issue(input logic [31:0] addr, input logic [31:0] data);
        chk("fetch_valid", ifu_req_valid, 1);
        chk("fetch_addr", ifu_req_addr, addr);
        ifu_req_ready = 1'b1;
        cyc();
        ifu_req_ready = 1'b0;
        chk("iwait_no_req", ifu_req_valid, 0);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data  = data;
        cyc();
        ifu_rsp_valid = 1'b0;
        chk("exec_inst_valid", inst_valid, 1);
        chk("exec_inst", inst, data);
    endtask

    // From a COMMIT-cycle negedge to the following FETCH-cycle negedge.
    task automatic commit_chk();
        chk("commit_pc_we", pc_we, 1);
        chk("commit_rf_we", rf_we_en, 1);
        chk("commit_no_inst_valid", inst_valid, 0);
        exp_cnt++;
        cyc();
        chk("retire_cnt", retire_cnt, exp_cnt);
        chk("retire_cnt4", retire_cnt4, exp_cnt % 16);
        chk("after_commit_pc_we", pc_we, 0);
    endtask

    task automatic run_alu(input logic [31:0] addr, input logic [31:0] data);
        fetch_issue(addr, data);
        is_mem = 1'b0;
        is_ebreak = 1'b0;
        cyc();
        commit_chk();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_cnt = 0;
        cyc();
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk_reset_vals("reset");
        rst = 1'b1;
        chk("idle_no_fetch", ifu_req_valid, 0);
        cyc();

        // First non-memory instruction
        run_alu(32'h8000_0000, 32'h0000_0093);

        // Load with LSU back-pressure and delayed response
        pc = 32'h8000_0004;
        fetch_issue(32'h8000_0004, 32'h0000_2083);
        is_mem = 1'b1;
        cyc();
        is_mem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mem_req_held", lsu_req_valid, 1);
            chk("mem_no_pc_we", pc_we, 0);
            cyc();
        end
        chk("mem_req_4th", lsu_req_valid, 1);
        lsu_req_ready = 1'b1;
        cyc();
        lsu_req_ready = 1'b0;
        chk("mwait_req_drop", lsu_req_valid, 0);
        cyc();
        chk("mwait_no_pc_we", pc_we, 0);
        lsu_rsp_valid = 1'b1;
        cyc();
        lsu_rsp_valid = 1'b0;
        commit_chk();

        // Ebreak has priority over is_mem
        pc = 32'h8000_0008;
        fetch_issue(32'h8000_0008, 32'h0010_0073);
        is_ebreak = 1'b1;
        is_mem = 1'b1;
        cyc();
        is_ebreak = 1'b0;
        is_mem = 1'b0;
        chk("ebreak_halted", halted, 1);
        chk("ebreak_no_timeout", timeout_err, 0);
        chk("ebreak_no_lsu", lsu_req_valid, 0);
        chk("ebreak_no_pc_we", pc_we, 0);
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data = 32'hdead_beef;
        lsu_rsp_valid = 1'b1;
        repeat (3) cyc();
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        chk("halt_sticky", halted, 1);
        chk("halt_inst_kept", inst, 32'h0010_0073);
        chk("halt_retire", retire_cnt, exp_cnt);
        chk("halt_no_fetch", ifu_req_valid, 0);

        // Watchdog timeout after 8 cycles in IWAIT
        do_reset();
        chk("to_fetch", ifu_req_valid, 1);
        ifu_req_ready = 1'b1;
        cyc();
        ifu_req_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("to_waiting", halted, 0);
            cyc();
        end
        chk("to_halted", halted, 1);
        chk("to_err", timeout_err, 1);

        // Response on the 8th IWAIT cycle beats the timeout
        do_reset();
        chk("to2_timeout_clear", timeout_err, 0);
        ifu_req_ready = 1'b1;
        cyc();
        ifu_req_ready = 1'b0;
        repeat (7) cyc();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_data = 32'h0000_0113;
        cyc();
        ifu_rsp_valid = 1'b0;
        chk("to2_not_halted", halted, 0);
        chk("to2_exec", inst_valid, 1);
        chk("to2_inst", inst, 32'h0000_0113);
        cyc();
        chk("to2_no_err", timeout_err, 0);
        commit_chk();

        // Reset asserted during MWAIT, then a stale LSU response
        pc = 32'h8000_0010;
        fetch_issue(32'h8000_0010, 32'h0000_a103);
        is_mem = 1'b1;
        lsu_req_ready = 1'b1;
        cyc();
        is_mem = 1'b0;
        chk("rm_mem", lsu_req_valid, 1);
        cyc();
        lsu_req_ready = 1'b0;
        chk("rm_mwait", lsu_req_valid, 0);
        rst = 1'b0;
        cyc();
        exp_cnt = 0;
        chk_reset_vals("rm");
        rst = 1'b1;
        lsu_rsp_valid = 1'b1;
        cyc();
        lsu_rsp_valid = 1'b0;
        chk("rm_stale_no_pc_we", pc_we, 0);
        chk("rm_refetch_valid", ifu_req_valid, 1);
        chk("rm_refetch_addr", ifu_req_addr, 32'h8000_0010);
        cyc();
        chk("rm_fetch_held", ifu_req_valid, 1);
        chk("rm_no_commit", retire_cnt, 0);
        run_alu(32'h8000_0010, 32'h0000_0193);

        // 100 back-to-back instructions from reset; 4-bit counter wraps
        do_reset();
        for (int i = 0; i < 100; i++) begin
            pc = 32'h8000_0000 + 32'(i * 4);
            run_alu(pc, 32'h0000_0013 | (32'(i) << 20));
            if (i == 15) chk("wrap16_cnt4", retire_cnt4, 0);
        end
        chk("b2b_retire100", retire_cnt, 100);
        chk("b2b_cnt4", retire_cnt4, 4);
        chk("b2b_not_halted", halted, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, failed);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_seq_ctrl.md
Name: exec_seq_ctrl

Overview:
- Multi-cycle sequencer for the core's PC update datapath, instruction memory port and load/store unit.
- Issues the instruction fetch for the current PC and latches the returned instruction. Issues the memory access for load/store instructions, then asserts the commit strobes that let the PC register and register file update.
- Provides halt on ebreak, a watchdog timeout on memory waits, and a retired-instruction count for the simulation environment.

Parameters:
- DATA_WIDTH, 32, width of PC, fetch address and instruction.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in any single wait state before a timeout halt.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- pc  in  DATA_WIDTH  current PC from the PC register
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  instruction memory accepts request
- ifu_req_addr  out  DATA_WIDTH  fetch address
- ifu_rsp_valid  in  1  instruction data valid
- ifu_rsp_data  in  32  fetched instruction
- inst  out  32  latched instruction register
- inst_valid  out  1  one-cycle pulse: inst is decodable this cycle
- is_mem  in  1  decoded load/store, sampled in EXEC
- is_ebreak  in  1  decoded ebreak, sampled in EXEC
- lsu_req_valid  out  1  load/store request valid
- lsu_req_ready  in  1  LSU accepts request
- lsu_rsp_valid  in  1  LSU access complete
- pc_we  out  1  PC register write enable (one-cycle pulse)
- rf_we_en  out  1  register-file write gate (one-cycle pulse)
- halted  out  1  sticky halt
- timeout_err  out  1  sticky, set when the halt was caused by timeout
- retire_cnt  out  CNT_WIDTH  committed instruction count

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - ifu_req_valid, lsu_req_valid, inst_valid, pc_we, rf_we_en, halted, timeout_err = 0.
  - inst = 32'h00000013 (nop); retire_cnt = 0; watchdog = 0.
  - Reset asserted mid-operation abandons the instruction. Responses arriving after reset are ignored because IDLE does not sample them.
- FSM states and transitions:
  - IDLE: go to FETCH next cycle.
  - FETCH: ifu_req_valid=1, ifu_req_addr=pc, both held stable until ifu_req_ready=1. On handshake go to IWAIT.
  - IWAIT: when ifu_rsp_valid=1, inst <= ifu_rsp_data and go to EXEC. The response is sampled only in IWAIT; memory responds no earlier than the cycle after acceptance.
  - EXEC: inst_valid=1 for exactly this cycle.
    - is_ebreak=1 -> HALT, no commit. is_ebreak has priority over is_mem.
    - else is_mem=1 -> MEM.
    - else -> COMMIT.
  - MEM: lsu_req_valid=1 until lsu_req_ready=1, then go to MWAIT.
  - MWAIT: when lsu_rsp_valid=1, go to COMMIT. Sampled only in MWAIT.
  - COMMIT: pc_we=1, rf_we_en=1, retire_cnt <= retire_cnt+1 (wraps modulo 2^CNT_WIDTH), then go to FETCH.
  - HALT: halted=1, all request and strobe outputs 0, absorbing until reset.
- Output timing: all outputs are Moore (decoded from registered state), except ifu_req_addr, which follows pc combinationally. pc is stable outside COMMIT.
- Watchdog:
  - Counter clears on every state change.
  - Increments each cycle spent in FETCH, IWAIT, MEM or MWAIT.
  - When it reaches TIMEOUT_CYCLES-1 in a state with no progress that cycle, the FSM goes to HALT with timeout_err=1.
  - Progress (handshake or response) on the same cycle takes priority over timeout.
- Latency: a non-memory instruction with zero-wait memory takes 4 cycles (FETCH, IWAIT, EXEC, COMMIT); a load/store takes 6. The first FETCH follows IDLE by one cycle.
- Simultaneous ifu_req_ready and ifu_rsp_valid in FETCH: ifu_rsp_valid is ignored.

Test Plan:
- Release reset with pc=0x80000000, ifu_req_ready=1, response one cycle later with 0x00000093, is_mem=0 -> ifu_req_addr=0x80000000 in FETCH; inst=0x00000093; inst_valid pulses once; pc_we and rf_we_en pulse 3 cycles after FETCH; retire_cnt=1.
- Load: is_mem=1 in EXEC, lsu_req_ready low for 3 cycles, lsu_rsp_valid 2 cycles after acceptance -> lsu_req_valid held 4 cycles; pc_we only after lsu_rsp_valid; retire_cnt increments by 1.
- Ebreak: is_ebreak=1 and is_mem=1 in EXEC -> halted=1 next cycle; no lsu_req_valid, no pc_we; retire_cnt unchanged; further ifu_rsp_valid ignored.
- Timeout: TIMEOUT_CYCLES=8, ifu_rsp_valid never asserted -> halted=1 and timeout_err=1 after 8 cycles in IWAIT. Repeat with the response on cycle 8 -> no timeout, normal commit.
- Reset mid-MWAIT: assert rst=0 for 1 cycle while in MWAIT, then deliver a stale lsu_rsp_valid -> all outputs at reset values; no pc_we; next FETCH re-issues the current pc.
- Back-to-back run: 100 non-memory instructions with zero-wait memory -> retire_cnt=100 after 400 cycles post-IDLE. Preload retire_cnt wrap test with CNT_WIDTH=4: 16 commits -> 0.
